// File: rtl/uplink_frame_tx.sv
// rtl/uplink_frame_tx.sv - serial uplink frame transmitter with preamble, gap and Msg-ID/Msg-data sequencing
module uplink_frame_tx #(
    parameter int LONG_FRAME_BITS  = 80,
    parameter int SHORT_FRAME_BITS = 24,
    parameter int PREAMBLE_COUNT   = 8,
    parameter int GAP_BITS         = 2,
    parameter int DIV_WIDTH        = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIV_WIDTH-1:0]       clk_div,
    input  logic                       frm_valid,
    input  logic                       frm_enc_used,
    input  logic [LONG_FRAME_BITS-1:0] frm_data,
    input  logic [7:0]                 frm_msg_len,
    output logic                       frm_ready,
    output logic                       ul_out,
    output logic                       ul_en,
    output logic [7:0]                 msg_cnt,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       proto_err
);

    // bit_idx must count up to the longest phase (payload of a long frame)
    localparam int IDX_W = $clog2(LONG_FRAME_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} state_t;

    state_t                     state, state_d;
    logic [DIV_WIDTH-1:0]       div_q;
    logic [DIV_WIDTH-1:0]       cnt, cnt_d;
    logic [IDX_W-1:0]           bit_idx, bit_idx_d;
    logic [IDX_W-1:0]           frame_len;
    logic [LONG_FRAME_BITS-1:0] shreg, shreg_d;
    logic                       is_id_q;
    logic                       expect_id;
    logic [7:0]                 msg_len;

    logic                       accept_ok;
    logic                       accept_bad;
    logic                       tick;
    logic                       last_bit;
    logic [8:0]                 cnt_sum;
    logic [7:0]                 cnt_capped;
    logic                       ul_out_d, ul_en_d, frame_done_d, proto_err_d;

    assign frm_ready  = (state == S_IDLE) && frm_valid;
    assign accept_ok  = frm_ready && (frm_enc_used == expect_id);
    assign accept_bad = frm_ready && (frm_enc_used != expect_id);
    assign tick       = (cnt == div_q);
    assign busy       = (state != S_IDLE);

    // Data-frame byte accounting saturates at the announced message length
    assign cnt_sum    = {1'b0, msg_cnt} + 9'd7;
    assign cnt_capped = (cnt_sum > {1'b0, msg_len}) ? msg_len : cnt_sum[7:0];

    // Last bit of the current phase
    always_comb begin
        last_bit = 1'b0;
        case (state)
            S_PREAMBLE: last_bit = (bit_idx == IDX_W'(PREAMBLE_COUNT - 1));
            S_PAYLOAD:  last_bit = (bit_idx == frame_len - IDX_W'(1));
            S_GAP:      last_bit = (bit_idx == IDX_W'(GAP_BITS - 1));
            default:    last_bit = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: each phase advances on the boundary of its last bit
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (accept_ok)       state_d = S_PREAMBLE;
            S_PREAMBLE: if (tick && last_bit) state_d = S_PAYLOAD;
            S_PAYLOAD:  if (tick && last_bit) state_d = S_GAP;
            S_GAP:      if (tick && last_bit) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath next values: bit timer, phase bit index and payload shifter
    always_comb begin
        cnt_d     = '0;
        bit_idx_d = '0;
        shreg_d   = shreg;
        if (state != S_IDLE) begin
            cnt_d     = tick ? '0 : cnt + DIV_WIDTH'(1);
            bit_idx_d = bit_idx;
            if (tick) begin
                bit_idx_d = last_bit ? '0 : bit_idx + IDX_W'(1);
            end
        end
        if (accept_ok) begin
            if (frm_enc_used) begin
                shreg_d = {{(LONG_FRAME_BITS - SHORT_FRAME_BITS){1'b0}}, frm_data[SHORT_FRAME_BITS-1:0]};
            end else begin
                shreg_d = frm_data;
            end
        end else if (state == S_PAYLOAD && tick) begin
            shreg_d = shreg >> 1;
        end
    end

    // Output logic: next values of the registered outputs, derived from the next state
    always_comb begin
        ul_en_d      = (state_d == S_PREAMBLE) || (state_d == S_PAYLOAD);
        ul_out_d     = 1'b0;
        if (state_d == S_PREAMBLE) begin
            ul_out_d = ~bit_idx_d[0];
        end else if (state_d == S_PAYLOAD) begin
            ul_out_d = shreg_d[0];
        end
        frame_done_d = (state == S_GAP) && tick && last_bit;
        proto_err_d  = accept_bad;
    end

    // Datapath registers; frame parameters are frozen at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            div_q     <= '0;
            frame_len <= '0;
            is_id_q   <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
            if (accept_ok) begin
                div_q     <= clk_div;
                frame_len <= frm_enc_used ? IDX_W'(SHORT_FRAME_BITS) : IDX_W'(LONG_FRAME_BITS);
                is_id_q   <= frm_enc_used;
            end
        end
    end

    // Message sequencing: ID frame opens a message, data frames fill it until msg_len is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expect_id <= 1'b1;
            msg_len   <= '0;
            msg_cnt   <= '0;
        end else if (accept_ok) begin
            if (frm_enc_used) begin
                msg_len <= frm_msg_len;
                msg_cnt <= '0;
            end else begin
                msg_cnt <= cnt_capped;
            end
        end else if (frame_done_d) begin
            if (is_id_q) begin
                expect_id <= 1'b0;
            end else if (msg_cnt >= msg_len) begin
                expect_id <= 1'b1;
                msg_cnt   <= '0;
            end
        end
    end

    // Registered serial and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ul_out     <= 1'b0;
            ul_en      <= 1'b0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            ul_out     <= ul_out_d;
            ul_en      <= ul_en_d;
            frame_done <= frame_done_d;
            proto_err  <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_uplink_frame_tx.sv
// tb/tb_uplink_frame_tx.sv - directed self-checking bench for uplink_frame_tx
module tb_uplink_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  clk_div;
    logic        frm_valid;
    logic        frm_enc_used;
    logic [79:0] frm_data;
    logic [7:0]  frm_msg_len;
    logic        frm_ready;
    logic        ul_out;
    logic        ul_en;
    logic [7:0]  msg_cnt;
    logic        busy;
    logic        frame_done;
    logic        proto_err;

    int vectors     = 0;
    int miscompares = 0;

    uplink_frame_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_div      (clk_div),
        .frm_valid    (frm_valid),
        .frm_enc_used (frm_enc_used),
        .frm_data     (frm_data),
        .frm_msg_len  (frm_msg_len),
        .frm_ready    (frm_ready),
        .ul_out       (ul_out),
        .ul_en        (ul_en),
        .msg_cnt      (msg_cnt),
        .busy         (busy),
        .frame_done   (frame_done),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle. Presents one frame, follows it
    // cycle by cycle through preamble, payload and gap, and returns at the
    // negedge where frame_done should be high.
    task automatic run_frame(input logic enc, input logic [79:0] data, input logic [7:0] mlen,
                             input logic [7:0] div, input logic [7:0] alt_div, input logic [7:0] exp_cnt);
        int  nbits;
        int  en_cycles;
        logic exp_bit;
        nbits        = 8 + (enc ? 24 : 80);
        en_cycles    = 0;
        frm_valid    = 1'b1;
        frm_enc_used = enc;
        frm_data     = data;
        frm_msg_len  = mlen;
        clk_div      = div;
        #1;
        chk("ready_at_offer", frm_ready, 1'b1);
        @(negedge clk);
        frm_valid = 1'b0;
        clk_div   = alt_div;
        chk("msg_cnt_after_accept", msg_cnt, exp_cnt);
        chk("proto_err_on_good", proto_err, 1'b0);
        for (int b = 0; b < nbits; b++) begin
            exp_bit = (b < 8) ? ((b % 2) == 0) : data[b-8];
            for (int c = 0; c <= int'(div); c++) begin
                chk("ul_en_active", ul_en, 1'b1);
                chk("ul_out_bit", ul_out, exp_bit);
                if (ul_en === 1'b1) en_cycles++;
                @(negedge clk);
            end
        end
        chk("en_window_cycles", en_cycles, nbits * (int'(div) + 1));
        for (int c = 0; c < 2 * (int'(div) + 1); c++) begin
            chk("gap_ul_en", ul_en, 1'b0);
            chk("gap_ul_out", ul_out, 1'b0);
            chk("gap_busy", busy, 1'b1);
            chk("gap_no_done", frame_done, 1'b0);
            @(negedge clk);
        end
        chk("frame_done_pulse", frame_done, 1'b1);
        chk("idle_after_frame", busy, 1'b0);
    endtask

    // Presents a frame of the wrong type and checks it is dropped
    task automatic wrong_frame(input logic enc);
        frm_valid    = 1'b1;
        frm_enc_used = enc;
        frm_data     = 80'h1234;
        frm_msg_len  = 8'd99;
        #1;
        chk("ready_on_wrong", frm_ready, 1'b1);
        @(negedge clk);
        frm_valid = 1'b0;
        chk("proto_err_pulse", proto_err, 1'b1);
        chk("wrong_no_en", ul_en, 1'b0);
        chk("wrong_not_busy", busy, 1'b0);
        @(negedge clk);
        chk("proto_err_one_cycle", proto_err, 1'b0);
        chk("wrong_still_no_en", ul_en, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        clk_div      = 8'd0;
        frm_valid    = 1'b0;
        frm_enc_used = 1'b0;
        frm_data     = '0;
        frm_msg_len  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_ul_out", ul_out, 1'b0);
        chk("rst_ul_en", ul_en, 1'b0);
        chk("rst_msg_cnt", msg_cnt, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_ready", frm_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Message of 14 bytes: ID then two data frames, back to back
        run_frame(1'b1, 80'hA5C3F0, 8'd14, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("done_clears", frame_done, 1'b0);
        run_frame(1'b0, 80'h0123_4567_89AB_CDEF_F00D, 8'd0, 8'd0, 8'd0, 8'd7);
        chk("cnt_mid_msg", msg_cnt, 8'd7);
        run_frame(1'b0, 80'hFEDC_BA98_7654_3210_5A5A, 8'd0, 8'd0, 8'd0, 8'd14);
        chk("cnt_cleared_at_end", msg_cnt, 8'd0);

        // msg_len = 0 still needs one data frame, then an ID is expected again
        run_frame(1'b1, 80'h00F00F, 8'd0, 8'd0, 8'd0, 8'd0);
        run_frame(1'b0, 80'hAAAA_5555_0000_FFFF_C3C3, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("cnt_zero_len", msg_cnt, 8'd0);
        @(negedge clk);
        wrong_frame(1'b0);

        // Slow bit clock, with clk_div changed mid-frame
        run_frame(1'b1, 80'h3C96E1, 8'd3, 8'd3, 8'd1, 8'd0);
        @(negedge clk);
        wrong_frame(1'b1);
        run_frame(1'b0, 80'h8000_0000_0000_0000_0001, 8'd0, 8'd1, 8'd1, 8'd3);
        chk("cnt_sat_end", msg_cnt, 8'd0);

        // Reset in the middle of a data frame payload
        run_frame(1'b1, 80'h000001, 8'd20, 8'd0, 8'd0, 8'd0);
        frm_valid    = 1'b1;
        frm_enc_used = 1'b0;
        frm_data     = {80{1'b1}};
        @(negedge clk);
        frm_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst_en", ul_en, 1'b1);
        chk("pre_rst_out", ul_out, 1'b1);
        chk("pre_rst_cnt", msg_cnt, 8'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ul_out", ul_out, 1'b0);
        chk("async_rst_ul_en", ul_en, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_cnt", msg_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1'b1, 80'h5A5A5A, 8'd7, 8'd0, 8'd0, 8'd0);
        run_frame(1'b0, 80'h1111_2222_3333_4444_5555, 8'd0, 8'd0, 8'd0, 8'd7);
        chk("final_cnt", msg_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
